stall_flush_controller: RTL and testbench

//  Pipeline control unit directly downstream of hazard detection. Merges the ID-stage

---
 rtl/stall_flush_controller.sv | 168 ++++++++++++++++
 tb/tb_stall_flush_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stall_flush_controller.sv
// Pipeline stall/flush controller.
// Merges the ID hazard flag, the EXE branch-taken flag and the MEM SRAM handshake
// into per-register freeze/flush/bubble controls. A taken branch seen during a memory
// wait is remembered and applied once the wait ends. Saturating statistics counters
// and a sticky hazard-livelock watchdog are kept alongside.
module stall_flush_controller #(
    parameter int CNT_W      = 16,
    parameter int MAX_HAZARD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             sram_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_freeze,
    output logic             id_ex_bubble,
    output logic             ex_mem_freeze,
    output logic             mem_wb_bubble,
    output logic             hazard_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int CONSEC_W = $clog2(MAX_HAZARD + 1);
    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_HAZARD);

    typedef enum logic [1:0] {
        CLS_RUN     = 2'd0,
        CLS_HAZARD  = 2'd1,
        CLS_FLUSH   = 2'd2,
        CLS_MEMWAIT = 2'd3
    } cls_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic                flush_pending_r;
    logic [CONSEC_W-1:0] consec_r;
    logic [CONSEC_W-1:0] consec_nxt_s;
    logic                timeout_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic [CNT_W-1:0]    memwait_cnt_r;
    logic [CNT_W-1:0]    flush_cnt_r;
    cls_t                cls_s;

    // Select the single active control class by strict priority.
    always_comb begin
        cls_s = CLS_RUN;
        if (mem_access && !sram_ready) begin
            cls_s = CLS_MEMWAIT;
        end else if (branch_taken || flush_pending_r) begin
            cls_s = CLS_FLUSH;
        end else if (hazard_detected) begin
            cls_s = CLS_HAZARD;
        end else begin
            cls_s = CLS_RUN;
        end
    end

    // Decode the class into register controls; everything is held low during reset.
    always_comb begin
        pc_freeze     = 1'b0;
        if_id_freeze  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_freeze  = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_freeze = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            pc_freeze = 1'b0;
        end else begin
            case (cls_s)
                CLS_MEMWAIT: begin
                    pc_freeze     = 1'b1;
                    if_id_freeze  = 1'b1;
                    id_ex_freeze  = 1'b1;
                    ex_mem_freeze = 1'b1;
                    mem_wb_bubble = 1'b1;
                end
                CLS_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                CLS_HAZARD: begin
                    pc_freeze    = 1'b1;
                    if_id_freeze = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    pc_freeze = 1'b0;
                end
            endcase
        end
    end

    // Next value of the consecutive-hazard run length.
    always_comb begin
        consec_nxt_s = consec_r;
        case (cls_s)
            CLS_HAZARD: begin
                if (consec_r != CONSEC_MAX) begin
                    consec_nxt_s = consec_r + {{(CONSEC_W-1){1'b0}}, 1'b1};
                end else begin
                    consec_nxt_s = consec_r;
                end
            end
            CLS_MEMWAIT: consec_nxt_s = consec_r;
            default:     consec_nxt_s = {CONSEC_W{1'b0}};
        endcase
    end

    // Remember a branch taken during a memory wait until the wait ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pending_r <= 1'b0;
        end else if (cls_s == CLS_MEMWAIT) begin
            flush_pending_r <= flush_pending_r | branch_taken;
        end else if (cls_s == CLS_FLUSH) begin
            flush_pending_r <= 1'b0;
        end else begin
            flush_pending_r <= flush_pending_r;
        end
    end

    // Hazard run length and sticky livelock flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            consec_r  <= {CONSEC_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            consec_r  <= consec_nxt_s;
            timeout_r <= timeout_r | (consec_nxt_s == CONSEC_MAX);
        end
    end

    // Saturating per-class cycle statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r   <= {CNT_W{1'b0}};
            memwait_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (cls_s)
                CLS_HAZARD:  stall_cnt_r   <= sat_inc(stall_cnt_r);
                CLS_MEMWAIT: memwait_cnt_r <= sat_inc(memwait_cnt_r);
                CLS_FLUSH:   flush_cnt_r   <= sat_inc(flush_cnt_r);
                default:     stall_cnt_r   <= stall_cnt_r;
            endcase
        end
    end

    assign hazard_timeout = timeout_r;
    assign stall_cnt      = stall_cnt_r;
    assign memwait_cnt    = memwait_cnt_r;
    assign flush_cnt      = flush_cnt_r;

endmodule

// File: tb/tb_stall_flush_controller.sv
// Directed self-checking bench for stall_flush_controller.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_stall_flush_controller;

    localparam logic [6:0] C_RUN  = 7'b0000000;
    localparam logic [6:0] C_MEMW = 7'b1101011;
    localparam logic [6:0] C_FLSH = 7'b0010100;
    localparam logic [6:0] C_HAZ  = 7'b1100100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hazard_detected = 1'b1;
    logic        branch_taken    = 1'b1;
    logic        mem_access      = 1'b1;
    logic        sram_ready      = 1'b1;

    logic        pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze;
    logic        id_ex_bubble, ex_mem_freeze, mem_wb_bubble, hazard_timeout;
    logic [15:0] stall_cnt, memwait_cnt, flush_cnt;

    logic        s_pc_freeze, s_if_id_freeze, s_if_id_flush, s_id_ex_freeze;
    logic        s_id_ex_bubble, s_ex_mem_freeze, s_mem_wb_bubble, s_hazard_timeout;
    logic [3:0]  s_stall_cnt, s_memwait_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    stall_flush_controller #(.CNT_W(16), .MAX_HAZARD(8)) dut (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_access(mem_access), .sram_ready(sram_ready),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_ex_freeze(id_ex_freeze), .id_ex_bubble(id_ex_bubble),
        .ex_mem_freeze(ex_mem_freeze), .mem_wb_bubble(mem_wb_bubble),
        .hazard_timeout(hazard_timeout), .stall_cnt(stall_cnt),
        .memwait_cnt(memwait_cnt), .flush_cnt(flush_cnt)
    );

    stall_flush_controller #(.CNT_W(4), .MAX_HAZARD(8)) dut_small (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_access(mem_access), .sram_ready(sram_ready),
        .pc_freeze(s_pc_freeze), .if_id_freeze(s_if_id_freeze), .if_id_flush(s_if_id_flush),
        .id_ex_freeze(s_id_ex_freeze), .id_ex_bubble(s_id_ex_bubble),
        .ex_mem_freeze(s_ex_mem_freeze), .mem_wb_bubble(s_mem_wb_bubble),
        .hazard_timeout(s_hazard_timeout), .stall_cnt(s_stall_cnt),
        .memwait_cnt(s_memwait_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl();
        return {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze,
                id_ex_bubble, ex_mem_freeze, mem_wb_bubble};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs just after the falling edge and settle.
    task automatic cyc(input logic h, input logic b, input logic m, input logic r);
        @(negedge clk);
        hazard_detected = h;
        branch_taken    = b;
        mem_access      = m;
        sram_ready      = r;
        #1;
    endtask

    initial begin
        // Reset held with every input high.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", 32'(ctrl()), 32'(C_RUN));
        chk("rst_cnt", {stall_cnt, memwait_cnt}, 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_timeout", 32'(hazard_timeout), 32'd0);

        // Release into a memory wait.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_memw_ctrl", 32'(ctrl()), 32'(C_RUN));
        rst = 1'b1;
        #1;
        chk("release_memw", 32'(ctrl()), 32'(C_MEMW));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("release_run", 32'(ctrl()), 32'(C_RUN));
        chk("release_memwait_cnt", 32'(memwait_cnt), 32'd1);

        // Reset in the middle of a wait discards the pending flush.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pend_memw", 32'(ctrl()), 32'(C_MEMW));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pend_flush_before_rst", 32'(ctrl()), 32'(C_FLSH));
        rst = 1'b0;
        #1;
        chk("midrst_ctrl", 32'(ctrl()), 32'(C_RUN));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_release_run", 32'(ctrl()), 32'(C_RUN));
        chk("midrst_cnt", {stall_cnt, memwait_cnt}, 32'd0);

        // Three hazard cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("haz3_ctrl", 32'(ctrl()), 32'(C_HAZ));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("haz3_run", 32'(ctrl()), 32'(C_RUN));
        chk("haz3_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("haz3_timeout", 32'(hazard_timeout), 32'd0);

        // Four wait cycles with a branch in the second, then the deferred flush.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, (i == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            chk("wait4_ctrl", 32'(ctrl()), 32'(C_MEMW));
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("wait4_flush", 32'(ctrl()), 32'(C_FLSH));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wait4_run", 32'(ctrl()), 32'(C_RUN));
        chk("wait4_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("wait4_memwait_cnt", 32'(memwait_cnt), 32'd4);

        // Branch wins over a simultaneous hazard.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("br_haz_ctrl", 32'(ctrl()), 32'(C_FLSH));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_haz_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("br_haz_flush_cnt", 32'(flush_cnt), 32'd2);

        // Seven hazard cycles, a RUN gap, seven more: watchdog stays quiet.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd_gap_timeout", 32'(hazard_timeout), 32'd0);
        chk("wd_gap_stall_cnt", 32'(stall_cnt), 32'd17);

        // Eight consecutive hazard cycles trip the watchdog on the eighth edge.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wd_7_timeout", 32'(hazard_timeout), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd_8_timeout", 32'(hazard_timeout), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd_sticky", 32'(hazard_timeout), 32'd1);
        chk("wd_stall_cnt", 32'(stall_cnt), 32'd25);

        // Fresh reset, then 20 hazard cycles: 4-bit counter saturates at 15.
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_rst_timeout", 32'(hazard_timeout), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_small_stall_cnt", 32'(s_stall_cnt), 32'd15);
        chk("sat_big_stall_cnt", 32'(stall_cnt), 32'd20);
        chk("sat_small_timeout", 32'(s_hazard_timeout), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
